wm_cycle_sequencer: RTL

- Program sequencer for the washing-machine top: turns the start/pause buttons and the water-level sensors into a timed FILL -> WASH -> DRAIN -> SPIN -> DONE sequence.
- Drives the valve, motor, drain and door-lock actuators.
- Reports progress on a phase code, a done flag (feeds the top-level `out`) and a latched fault flag.

---
 rtl/wm_cycle_sequencer_if.sv | 26 ++
 rtl/wm_cycle_sequencer.sv | 99 +++++++++
 2 files changed

// File: rtl/wm_cycle_sequencer_if.sv
// Command/status bundle between the washing-machine top and its program sequencer.
// Buttons and level sensors flow in; actuator enables and progress flags flow out.
interface wm_cycle_sequencer_if;
  logic       start_button;
  logic       pause_button;
  logic       level_full;
  logic       level_empty;
  logic       valve_open;
  logic       drain_open;
  logic       motor_on;
  logic       motor_fast;
  logic       door_lock;
  logic [2:0] phase;
  logic       done;
  logic       fault;

  modport master (
    output start_button, pause_button, level_full, level_empty,
    input  valve_open, drain_open, motor_on, motor_fast, door_lock, phase, done, fault
  );

  modport slave (
    input  start_button, pause_button, level_full, level_empty,
    output valve_open, drain_open, motor_on, motor_fast, door_lock, phase, done, fault
  );
endinterface

// File: rtl/wm_cycle_sequencer.sv
// Timed FILL -> WASH -> DRAIN -> SPIN -> DONE program sequencer with pause and
// sensor timeouts; actuator outputs are a Moore decode of state and registered pause.
module wm_cycle_sequencer #(
  parameter int TW            = 16,
  parameter int WASH_CYC      = 400,
  parameter int SPIN_CYC      = 200,
  parameter int FILL_TIMEOUT  = 300,
  parameter int DRAIN_TIMEOUT = 300
) (
  input  logic                  clk,
  input  logic                  reset,
  wm_cycle_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5,
    S_FAULT = 3'd7
  } state_t;

  localparam logic [TW-1:0] WASH_LAST  = TW'(WASH_CYC - 1);
  localparam logic [TW-1:0] SPIN_LAST  = TW'(SPIN_CYC - 1);
  localparam logic [TW-1:0] FILL_LAST  = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          paused_q;
  logic          timed_state;

  assign timed_state = (state == S_FILL) || (state == S_WASH) ||
                       (state == S_DRAIN) || (state == S_SPIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      paused_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      paused_q <= bus.pause_button;
      // Every state entry restarts the timer so each phase counts from zero.
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timed_state && !paused_q) begin
        timer <= timer + TIMER_ONE;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start_button) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (!paused_q) begin
          if (bus.level_full)          state_nxt = S_WASH;
          else if (timer == FILL_LAST) state_nxt = S_FAULT;
        end
      end
      S_WASH: begin
        if (!paused_q && timer == WASH_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!paused_q) begin
          if (bus.level_empty)          state_nxt = S_SPIN;
          else if (timer == DRAIN_LAST) state_nxt = S_FAULT;
        end
      end
      S_SPIN: begin
        if (!paused_q && timer == SPIN_LAST) state_nxt = S_DONE;
      end
      // A held start must be released before another program can launch.
      S_DONE: begin
        if (!bus.start_button) state_nxt = S_IDLE;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.valve_open = (state == S_FILL) && !paused_q;
  assign bus.motor_on   = ((state == S_WASH) || (state == S_SPIN)) && !paused_q;
  assign bus.motor_fast = (state == S_SPIN) && !paused_q;
  assign bus.drain_open = (state == S_DRAIN) && !paused_q;
  assign bus.door_lock  = timed_state;
  assign bus.done       = (state == S_DONE);
  assign bus.fault      = (state == S_FAULT);
  assign bus.phase      = state;

endmodule
